banco_reg_param: RTL and testbench
==================================

BANCO_REG_PARAM -- requirements
Module: banco_reg_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; depth DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning that when it is 1, register 0 is hardwired to zero and is never marked pending.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have port we, input, 1 bit, write enable.
REQ-007 The block SHALL have port wr, input, ADDR_W bits, write address.
REQ-008 The block SHALL have port wd, input, DATA_W bits, write data.
REQ-009 The block SHALL have ports rr1 and rr2, input, ADDR_W bits each, read addresses for ports 1 and 2.
REQ-010 The block SHALL have ports rd1 and rd2, output, DATA_W bits each, read data for ports 1 and 2.
REQ-011 The block SHALL have port issue, input, 1 bit, which marks destination issue_rd as pending.
REQ-012 The block SHALL have port issue_rd, input, ADDR_W bits, the destination of an issued instruction.
REQ-013 The block SHALL have ports busy1 and busy2, output, 1 bit each, asserted when rr1 or rr2 (respectively) holds a pending value.
REQ-014 The block SHALL have port ready, output, 1 bit, high once initialisation is complete.

Function
REQ-015 The block SHALL implement a two-state FSM, CLEAR and RUN; CLEAR is entered on rst.
REQ-016 In CLEAR, the block SHALL write zero to register clr_cnt each cycle, with clr_cnt running from 0 to DEPTH-1, and SHALL move to RUN on the cycle after clr_cnt = DEPTH-1 is written.
REQ-017 ready SHALL equal 1 exactly when the FSM is in RUN; CLEAR lasts DEPTH cycles after rst deasserts.
REQ-018 In CLEAR, the block SHALL ignore we and issue, and SHALL drive rd1, rd2, busy1 and busy2 to 0.
REQ-019 In RUN, a write SHALL commit wd to regs[wr] on the clock edge when we = 1, except when ZERO_REG = 1 and wr = 0 (write dropped).
REQ-020 Reads SHALL be combinational, with zero-cycle latency: rdN = regs[rrN].
REQ-021 Write-through bypass: when we = 1 and wr = rrN (write not dropped), rdN SHALL equal wd in the same cycle.
REQ-022 When ZERO_REG = 1 and rrN = 0, rdN SHALL be 0 regardless of bypass.
REQ-023 Scoreboard: pending is a vector of DEPTH bits; issue = 1 SHALL set pending[issue_rd] at the edge, except for register 0 when ZERO_REG = 1.
REQ-024 A committed write SHALL clear pending[wr] at the edge.
REQ-025 When issue and a write occur in the same cycle with issue_rd = wr, pending SHALL remain 1 (the new producer wins), and the data SHALL still be written.
REQ-026 busyN SHALL be pending[rrN] AND NOT (we AND wr = rrN), so a value being written this cycle is not reported busy.
REQ-027 Issue and write to different addresses in the same cycle SHALL both take effect.

Reset
REQ-028 Asserting rst, including mid-operation, SHALL immediately force FSM = CLEAR, clr_cnt = 0, and pending = all 0.
REQ-029 While rst is asserted, outputs SHALL be ready = 0, rd1 = rd2 = 0, busy1 = busy2 = 0.
REQ-030 Register contents SHALL not be reset asynchronously; they are zeroed by the CLEAR sweep.

Structure
REQ-031 The FSM state encoding and the defaults for DATA_W and ADDR_W SHALL live in a shared package, banco_pkg.
REQ-032 Scoreboard logic SHALL be a sub-module, reg_scoreboard, holding pending, set/clear and busy generation; storage, bypass and FSM SHALL stay in banco_reg_param.

Verification
REQ-033 Pulse rst, then hold idle -> ready = 0 for exactly 32 cycles, ready = 1 on cycle 33, and every read returns 0.
REQ-034 In RUN, write wr = 5, wd = 0xDEADBEEF, with rr1 = 5 in the same cycle -> rd1 = 0xDEADBEEF combinationally, and it holds on the next cycle with we = 0.
REQ-035 Write wr = 0, wd = 0xFFFFFFFF, with rr2 = 0 -> rd2 = 0 in the same cycle and all later cycles.
REQ-036 issue_rd = 7, then rr1 = 7 -> busy1 = 1; write wr = 7 -> busy1 = 0 in that cycle, and pending[7] = 0 after the edge.
REQ-037 Same-cycle issue_rd = 9 and write wr = 9, wd = 0x12 -> regs[9] = 0x12 and busy1 = 1 for rr1 = 9 on the next cycle.
REQ-038 Assert rst mid-RUN with pending[3] = 1 and regs[3] = 0x55 -> ready falls immediately, and after 32 cycles rd1 (rr1 = 3) = 0 and busy1 = 0.

Source files
------------

// File: rtl/banco_pkg.sv
// Shared definitions for the parameterised register bank: default geometry
// and the encoding of the initialisation/run state machine.
package banco_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_DEF = 1;

    // Kept as plain constants so older tools and netlists see a fixed encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-value scoreboard: one bit per register, set on issue, cleared on a
// committed write, with busy flags for the two read ports.
module reg_scoreboard
    import banco_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int DEPTH    = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              wr_commit,
    input  logic [ADDR_W-1:0] wr,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic              busy1,
    output logic              busy2
);

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic             set_en;

    assign set_en = en && issue && !((ZERO_REG != 0) && (issue_rd == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            assign set_vec[gi] = set_en && (issue_rd == ADDR_W'(gi));
            assign clr_vec[gi] = wr_commit && (wr == ADDR_W'(gi));
            // A fresh issue outranks the retiring write: the newer producer owns it
            assign pending_next[gi] = set_vec[gi] ? 1'b1 :
                                      clr_vec[gi] ? 1'b0 : pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign busy1 = en && pending_reg[rr1] && !(wr_commit && (wr == rr1));
    assign busy2 = en && pending_reg[rr2] && !(wr_commit && (wr == rr2));

endmodule

// File: rtl/banco_reg_param.sv
// Two-read, one-write register bank with write-through bypass, an optional
// hardwired zero register, a power-up clearing sweep and a pending scoreboard.
module banco_reg_param
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              busy1,
    output logic              busy2,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_next;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_commit;
    logic              wr_drop;

    assign ready     = (state_reg == ST_RUN);
    assign wr_drop   = (ZERO_REG != 0) && (wr == '0);
    assign wr_commit = ready && we && !wr_drop;

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == ST_CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == '1) begin
                state_next = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Storage has no reset of its own; the CLEAR sweep zeroes it one entry per cycle
    always_ff @(posedge clk) begin
        if (state_reg == ST_CLEAR) begin
            regs[clr_cnt_reg] <= '0;
        end else if (wr_commit) begin
            regs[wr] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        if (ready && !((ZERO_REG != 0) && (rr1 == '0))) begin
            rd1 = (wr_commit && (wr == rr1)) ? wd : regs[rr1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ready && !((ZERO_REG != 0) && (rr2 == '0))) begin
            rd2 = (wr_commit && (wr == rr2)) ? wd : regs[rr2];
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .DEPTH    (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .en        (ready),
        .issue     (issue),
        .issue_rd  (issue_rd),
        .wr_commit (wr_commit),
        .wr        (wr),
        .rr1       (rr1),
        .rr2       (rr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule

// File: tb/tb_banco_reg_param.sv
// Directed bench for banco_reg_param: clearing sweep, bypass, zero register,
// scoreboard set/clear interplay and mid-run reset.
module tb_banco_reg_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        issue;
    logic [4:0]  issue_rd;
    logic        busy1;
    logic        busy2;
    logic        ready;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    banco_reg_param dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wr       (wr),
        .wd       (wd),
        .rr1      (rr1),
        .rr2      (rr2),
        .rd1      (rd1),
        .rd2      (rd2),
        .issue    (issue),
        .issue_rd (issue_rd),
        .busy1    (busy1),
        .busy2    (busy2),
        .ready    (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, where inputs are changed
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wr = '0; wd = '0; issue = 1'b0; issue_rd = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        rr1 = '0; rr2 = '0;

        // Held in reset: everything quiet even with a write request present
        repeat (3) @(posedge clk);
        #1;
        we = 1'b1; wr = 5'd4; wd = 32'h1111_1111; rr1 = 5'd4;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rd1", rd1, 32'd0);
        chk("rst_busy", {30'b0, busy1, busy2}, 32'd0);
        idle();

        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk($sformatf("clear_ready_c%0d", i + 1), {31'b0, ready}, 32'd0);
        end
        @(negedge clk);
        chk("run_ready_c33", {31'b0, ready}, 32'd1);
        for (int i = 0; i < 32; i += 2) begin
            rr1 = 5'(i); rr2 = 5'(i + 1);
            #1;
            chk($sformatf("init_rd_%0d", i), rd1, 32'd0);
            chk($sformatf("init_rd_%0d", i + 1), rd2, 32'd0);
        end

        // Write-through bypass, then the stored value
        next_cycle();
        we = 1'b1; wr = 5'd5; wd = 32'hDEAD_BEEF; rr1 = 5'd5; rr2 = 5'd6;
        @(negedge clk);
        chk("bypass_rd1", rd1, 32'hDEAD_BEEF);
        chk("bypass_other_rd2", rd2, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("stored_rd1", rd1, 32'hDEAD_BEEF);

        // Register 0 stays zero
        next_cycle();
        we = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF; rr2 = 5'd0;
        @(negedge clk);
        chk("zero_bypass_rd2", rd2, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("zero_after_rd2", rd2, 32'd0);
        chk("zero_after_rd1_r5", rd1, 32'hDEAD_BEEF);

        // Bypass on port 1 while port 2 reads stored data
        next_cycle();
        we = 1'b1; wr = 5'd10; wd = 32'h0000_A5A5; rr1 = 5'd10; rr2 = 5'd5;
        @(negedge clk);
        chk("dual_rd1", rd1, 32'h0000_A5A5);
        chk("dual_rd2", rd2, 32'hDEAD_BEEF);

        // Issue to 7: pending only after the edge, cleared by the write
        next_cycle();
        idle();
        issue = 1'b1; issue_rd = 5'd7; rr1 = 5'd7;
        @(negedge clk);
        chk("issue7_same_cycle_busy1", {31'b0, busy1}, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("issue7_busy1", {31'b0, busy1}, 32'd1);
        next_cycle();
        we = 1'b1; wr = 5'd7; wd = 32'h0000_0077;
        @(negedge clk);
        chk("write7_busy1", {31'b0, busy1}, 32'd0);
        chk("write7_rd1", rd1, 32'h0000_0077);
        next_cycle();
        idle();
        @(negedge clk);
        chk("after7_busy1", {31'b0, busy1}, 32'd0);

        // Issue to register 0 is never recorded
        next_cycle();
        issue = 1'b1; issue_rd = 5'd0; rr2 = 5'd0;
        next_cycle();
        idle();
        @(negedge clk);
        chk("issue0_busy2", {31'b0, busy2}, 32'd0);

        // Same-cycle issue and write to 9: data lands, pending survives
        next_cycle();
        issue = 1'b1; issue_rd = 5'd9; we = 1'b1; wr = 5'd9; wd = 32'h0000_0012;
        rr1 = 5'd9; rr2 = 5'd9;
        @(negedge clk);
        chk("same9_rd1", rd1, 32'h0000_0012);
        chk("same9_busy1_now", {31'b0, busy1}, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("same9_rd1_next", rd1, 32'h0000_0012);
        chk("same9_busy1_next", {31'b0, busy1}, 32'd1);
        chk("same9_busy2_next", {31'b0, busy2}, 32'd1);

        // Issue and write to different registers together
        next_cycle();
        issue = 1'b1; issue_rd = 5'd3; we = 1'b1; wr = 5'd11; wd = 32'h0000_00BB;
        next_cycle();
        idle();
        rr1 = 5'd3; rr2 = 5'd11;
        @(negedge clk);
        chk("diff_busy1_r3", {31'b0, busy1}, 32'd1);
        chk("diff_rd2_r11", rd2, 32'h0000_00BB);
        chk("diff_busy2_r11", {31'b0, busy2}, 32'd0);

        // Give r3 a value while keeping it pending
        next_cycle();
        issue = 1'b1; issue_rd = 5'd3; we = 1'b1; wr = 5'd3; wd = 32'h0000_0055;
        next_cycle();
        idle();
        @(negedge clk);
        chk("r3_rd1", rd1, 32'h0000_0055);
        chk("r3_busy1", {31'b0, busy1}, 32'd1);

        // Mid-run reset takes effect without waiting for a clock edge
        next_cycle();
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'd0);
        chk("midrst_rd1", rd1, 32'd0);
        chk("midrst_busy1", {31'b0, busy1}, 32'd0);
        next_cycle();
        rst = 1'b0;
        // Requests during the sweep must be ignored
        we = 1'b1; wr = 5'd20; wd = 32'h0000_CAFE; issue = 1'b1; issue_rd = 5'd21;
        rr1 = 5'd20; rr2 = 5'd21;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk($sformatf("reclear_ready_c%0d", i + 1), {31'b0, ready}, 32'd0);
            if (i == 0 || i == 31) begin
                chk($sformatf("reclear_rd1_c%0d", i + 1), rd1, 32'd0);
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        chk("rerun_ready", {31'b0, ready}, 32'd1);
        chk("rerun_rd1_r20", rd1, 32'd0);
        chk("rerun_busy2_r21", {31'b0, busy2}, 32'd0);
        rr1 = 5'd3; rr2 = 5'd9;
        #1;
        chk("rerun_rd1_r3", rd1, 32'd0);
        chk("rerun_busy1_r3", {31'b0, busy1}, 32'd0);
        chk("rerun_busy2_r9", {31'b0, busy2}, 32'd0);
        chk("rerun_rd2_r9", rd2, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
